// File: rtl/microcode_sequencer.sv
// Control-store sequencer: copies EPROM into control-store RAM after reset, then steps upc per seq_op.
// Optional call/return stack built when `ECLAIR_SEQ_STACK_EN is defined; otherwise CALL=JUMP, RETURN=NEXT.
module microcode_sequencer #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WORD_WIDTH  = 64,
   parameter int NUM_COND    = 4,
   parameter int STACK_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic [ADDR_WIDTH-1:0]       rom_addr,
   input  logic [WORD_WIDTH-1:0]       rom_data,
   output logic                        ram_we,
   output logic [ADDR_WIDTH-1:0]       ram_addr,
   output logic [WORD_WIDTH-1:0]       ram_wdata,
   input  logic [2:0]                  seq_op,
   input  logic [ADDR_WIDTH-1:0]       seq_target,
   input  logic [ADDR_WIDTH-1:0]       opcode,
   input  logic [NUM_COND-1:0]         cond,
   input  logic [$clog2(NUM_COND)-1:0] cond_sel,
   input  logic                        stall,
   output logic [ADDR_WIDTH-1:0]       cs_addr,
   output logic                        cs_ready,
   output logic                        stack_err
);

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [2:0] OP_NEXT     = 3'd0;
   localparam logic [2:0] OP_JUMP     = 3'd1;
   localparam logic [2:0] OP_DISPATCH = 3'd2;
   localparam logic [2:0] OP_BRANCH   = 3'd3;
   localparam logic [2:0] OP_CALL     = 3'd4;
   localparam logic [2:0] OP_RETURN   = 3'd5;
   localparam logic [2:0] OP_HOLD     = 3'd6;
   localparam logic [2:0] OP_RESTART  = 3'd7;

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] load_cnt_q, load_cnt_d;
   logic [ADDR_WIDTH-1:0] upc_q, upc_d;
   logic [ADDR_WIDTH-1:0] upc_inc;

`ifdef ECLAIR_SEQ_STACK_EN
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

   // Array is padded to a power of two so sp_q always indexes in range.
   logic [ADDR_WIDTH-1:0] stack_q [2**SPW];
   logic [SPW-1:0]        sp_q, sp_d, sp_m1;
   logic                  err_q, err_d, push;

   assign sp_m1     = sp_q - 1'b1;
   assign stack_err = err_q;
`else
   assign stack_err = 1'b0;
`endif

   assign upc_inc   = upc_q + 1'b1;
   assign rom_addr  = load_cnt_q;
   assign ram_we    = (state_q == ST_LOAD) && !reset;
   assign ram_addr  = (state_q == ST_LOAD) ? load_cnt_q : upc_q;
   assign ram_wdata = rom_data;
   assign cs_addr   = upc_q;
   assign cs_ready  = (state_q == ST_RUN);

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      upc_d      = upc_q;
`ifdef ECLAIR_SEQ_STACK_EN
      sp_d       = sp_q;
      err_d      = err_q;
      push       = 1'b0;
`endif
      if (state_q == ST_LOAD) begin
         load_cnt_d = load_cnt_q + 1'b1;
         if (load_cnt_q == '1) begin
            state_d = ST_RUN;
            upc_d   = '0;
         end
      end else if (!stall) begin
         case (seq_op)
            OP_NEXT:     upc_d = upc_inc;
            OP_JUMP:     upc_d = seq_target;
            OP_DISPATCH: upc_d = opcode;
            OP_BRANCH:   upc_d = cond[cond_sel] ? seq_target : upc_inc;
            OP_CALL: begin
               upc_d = seq_target;
`ifdef ECLAIR_SEQ_STACK_EN
               if (sp_q == SP_FULL) begin
                  err_d = 1'b1;
               end else begin
                  push = !reset;
                  sp_d = sp_q + 1'b1;
               end
`endif
            end
            OP_RETURN: begin
`ifdef ECLAIR_SEQ_STACK_EN
               if (sp_q == '0) begin
                  upc_d = '0;
                  err_d = 1'b1;
               end else begin
                  upc_d = stack_q[sp_m1];
                  sp_d  = sp_m1;
               end
`else
               upc_d = upc_inc;
`endif
            end
            OP_HOLD:     upc_d = upc_q;
            OP_RESTART: begin
               upc_d = '0;
`ifdef ECLAIR_SEQ_STACK_EN
               sp_d  = '0;
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_LOAD;
         load_cnt_q <= '0;
         upc_q      <= '0;
`ifdef ECLAIR_SEQ_STACK_EN
         sp_q       <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         upc_q      <= upc_d;
`ifdef ECLAIR_SEQ_STACK_EN
         sp_q       <= sp_d;
         err_q      <= err_d;
`endif
      end
   end

`ifdef ECLAIR_SEQ_STACK_EN
   // Stack contents need no reset; sp_q alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (push) stack_q[sp_q] <= upc_inc;
   end
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed literal checks plus randomized ops against a queue-based model.
module tb_microcode_sequencer;
   localparam int AW = 4;
   localparam int WW = 8;
   localparam int NC = 4;
   localparam int SD = 2;
   localparam int D  = 1 << AW;

   localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, DISPATCH = 3'd2, BRANCH = 3'd3;
   localparam logic [2:0] CALL = 3'd4, RETURN = 3'd5, HOLD = 3'd6, RESTART = 3'd7;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rom_addr;
   logic [WW-1:0] rom_data;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [WW-1:0] ram_wdata;
   logic [2:0]    seq_op;
   logic [AW-1:0] seq_target;
   logic [AW-1:0] opcode;
   logic [NC-1:0] cond;
   logic [1:0]    cond_sel;
   logic          stall;
   logic [AW-1:0] cs_addr;
   logic          cs_ready;
   logic          stack_err;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 0;

   // Behavioural model state
   bit m_run;
   int m_cnt;
   int m_upc;
   int m_stack[$];
   bit m_err;

   assign rom_data = 8'hA5 ^ {4'h0, rom_addr};

   microcode_sequencer #(
      .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .NUM_COND(NC), .STACK_DEPTH(SD)
   ) dut (
      .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .seq_op(seq_op), .seq_target(seq_target), .opcode(opcode),
      .cond(cond), .cond_sel(cond_sel), .stall(stall),
      .cs_addr(cs_addr), .cs_ready(cs_ready), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_run = 0; m_cnt = 0; m_upc = 0; m_err = 0;
         m_stack.delete();
      end else if (!m_run) begin
         if (m_cnt == D - 1) begin
            m_run = 1;
            m_upc = 0;
         end
         m_cnt = (m_cnt + 1) % D;
      end else if (!stall) begin
         case (seq_op)
            NEXT:     m_upc = (m_upc + 1) % D;
            JUMP:     m_upc = seq_target;
            DISPATCH: m_upc = opcode;
            BRANCH:   m_upc = cond[cond_sel] ? int'(seq_target) : (m_upc + 1) % D;
            CALL: begin
`ifdef ECLAIR_SEQ_STACK_EN
               if (m_stack.size() == SD) m_err = 1;
               else m_stack.push_back((m_upc + 1) % D);
`endif
               m_upc = seq_target;
            end
            RETURN: begin
`ifdef ECLAIR_SEQ_STACK_EN
               if (m_stack.size() == 0) begin
                  m_upc = 0;
                  m_err = 1;
               end else begin
                  m_upc = m_stack.pop_back();
               end
`else
               m_upc = (m_upc + 1) % D;
`endif
            end
            HOLD: ;
            default: begin
               m_upc = 0;
               m_stack.delete();
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cs_addr", cs_addr, m_upc);
         check("cs_ready", cs_ready, m_run);
         check("stack_err", stack_err, m_err);
         check("ram_we", ram_we, !reset && !m_run);
         check("ram_addr", ram_addr, m_run ? m_upc : m_cnt);
         if (!m_run) begin
            check("rom_addr", rom_addr, m_cnt);
            check("ram_wdata", ram_wdata, 8'hA5 ^ m_cnt);
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic op(input logic [2:0] o, input logic [AW-1:0] t);
      seq_op = o;
      seq_target = t;
      cyc();
   endtask

   task automatic rand_run(input int n);
      for (int i = 0; i < n; i++) begin
         opcode   = AW'($urandom_range(0, D - 1));
         cond     = NC'($urandom_range(0, 15));
         cond_sel = 2'($urandom_range(0, 3));
         stall    = ($urandom_range(0, 4) == 0);
         op(3'($urandom_range(0, 7)), AW'($urandom_range(0, D - 1)));
      end
      stall = 0;
   endtask

   initial begin
      reset = 1; stall = 0; seq_op = NEXT; seq_target = 0; opcode = 0; cond = 0; cond_sel = 0;
      cyc();
      cyc();
      chk_en = 1;
      check("rst_cs_addr", cs_addr, 0);
      check("rst_cs_ready", cs_ready, 0);
      check("rst_stack_err", stack_err, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_rom_addr", rom_addr, 0);

      reset = 0;
      #1;
      check("load0_we", ram_we, 1);
      check("load0_wdata", ram_wdata, 8'hA5);
      repeat (15) cyc();
      check("load15_addr", ram_addr, 15);
      check("load15_wdata", ram_wdata, 8'hAA);
      check("load15_ready", cs_ready, 0);
      cyc();
      check("run_ready", cs_ready, 1);
      check("run_addr0", cs_addr, 0);
      check("run_we", ram_we, 0);

      op(JUMP, 15);     check("jump15", cs_addr, 15);
      op(NEXT, 0);      check("wrap", cs_addr, 0);
      op(JUMP, 9);      check("jump9", cs_addr, 9);
      opcode = 4'h3;
      op(DISPATCH, 0);  check("dispatch", cs_addr, 3);
      cond = 4'b0100; cond_sel = 2;
      op(BRANCH, 7);    check("branch_taken", cs_addr, 7);
      cond_sel = 1;
      op(BRANCH, 12);   check("branch_not", cs_addr, 8);

      op(CALL, 5);      check("call5", cs_addr, 5);
      op(CALL, 8);      check("call8", cs_addr, 8);
      op(CALL, 12);     check("call12", cs_addr, 12);
`ifdef ECLAIR_SEQ_STACK_EN
      check("ovf_err", stack_err, 1);
      op(RETURN, 0);    check("ret1", cs_addr, 6);
      op(RETURN, 0);    check("ret2", cs_addr, 9);
      op(RETURN, 0);    check("ret_empty", cs_addr, 0);
      check("udf_err", stack_err, 1);
`else
      check("nostack_err", stack_err, 0);
      op(RETURN, 0);    check("ret_as_next1", cs_addr, 13);
      op(RETURN, 0);    check("ret_as_next2", cs_addr, 14);
      op(RETURN, 0);    check("ret_as_next3", cs_addr, 15);
`endif

      op(JUMP, 10);     check("jump10", cs_addr, 10);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         op(JUMP, 3);
         check("stall_hold", cs_addr, 10);
      end
      stall = 0;
      op(JUMP, 3);      check("stall_release", cs_addr, 3);
      op(HOLD, 0);      check("hold", cs_addr, 3);
      op(RESTART, 0);   check("restart", cs_addr, 0);
      op(NEXT, 0);      check("after_restart", cs_addr, 1);

      reset = 1; cyc(); reset = 0;
      repeat (6) cyc();
      check("midload_cnt6", rom_addr, 6);
      reset = 1; cyc();
      check("midload_rom_addr", rom_addr, 0);
      check("midload_we", ram_we, 0);
      check("midload_ready", cs_ready, 0);
      reset = 0;
      repeat (16) cyc();
      check("reload_ready", cs_ready, 1);
      check("reload_addr", cs_addr, 0);

      rand_run(200);

      reset = 1; cyc();
      check("runrst_ready", cs_ready, 0);
      check("runrst_addr", cs_addr, 0);
      check("runrst_err", stack_err, 0);
      reset = 0;
      repeat (15) cyc();
      check("runrst_load15", cs_ready, 0);
      cyc();
      check("runrst_ready2", cs_ready, 1);

      rand_run(300);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
